mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Round-robin arbiter that shares one 4:1 single-bit multiplexer between four requesters. It samples four request lines, grants exactly one requester at a time, and drives the multiplexer address pair so the granted requester's input reaches the shared output. Grants are held until the owner releases its request. An optional hold-timeout forces rotation to a waiting requester. The block sits directly in front of the multiplexer's `address0`/`address1` inputs.

## Interface
- `MAX_HOLD`, 8: maximum consecutive grant cycles per owner when the timeout is compiled in; legal range 2..255.
- `clk`  input  1  single clock, rising-edge active.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  4  request lines; bit i = requester i (maps to mux input `in<i>`).
- `grant`  output  4  one-hot grant, registered; all zero when idle.
- `address0`  output  1  mux select LSB, equals index bit 0 of the current owner.
- `address1`  output  1  mux select MSB, equals index bit 1 of the current owner.
- `valid`  output  1  high when `grant` is nonzero; the mux output is meaningful only then.

## Operation
- States: IDLE (no owner) and BUSY (owner = `grant` index).
- Round-robin pointer `ptr[1:0]`: the search for the next owner starts at `ptr` and wraps 3→0. After any grant to index i, `ptr` becomes (i+1) mod 4.
- IDLE: if any `req` bit is set, grant the first set bit found from `ptr` upward, then enter BUSY. Otherwise stay in IDLE.
- BUSY, owner's `req` still high: hold the grant. The address outputs do not change.
- BUSY, owner's `req` low (release): on the same edge, pick the next owner from `ptr` among the set `req` bits (back-to-back handoff, no dead cycle). If there is none, enter IDLE, clear `grant`, and hold the address at its last value.
- A requester that releases and re-requests competes normally; it gets no priority boost.
- The address outputs always equal the encoded index of the current or last owner. They change only on a grant edge.
- `valid` = OR of `grant` bits, registered with `grant`.
- `req` bits for non-owners may toggle freely; only bits set on the sampling edge count.

## Timing
- Reset (asynchronous, immediate): `grant`=0000, `address1`/`address0`=00, `valid`=0, `ptr`=0, state IDLE, hold counter=0.
- Request to grant latency: 1 clock edge. A `req` that goes high before edge n gives `grant` high after edge n.
- Release to handoff: the owner's `req` sampled low at edge n gives the new `grant`, address, and `valid` after edge n.
- Simultaneous requests: resolved purely by `ptr` order.
- Reset asserted mid-grant: all outputs drop immediately. The first grant after reset searches from index 0.
- No combinational path from `req` to any output.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle.
  - When the counter reaches `MAX_HOLD`-1 and any other `req` bit is set, the next edge forces a handoff to the next requester from `ptr`, exactly as for a release.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates at `MAX_HOLD`-1.
- `MUX_ARB_TIMEOUT_EN` undefined: there is no counter, and ownership ends only on release.

## Test plan
- Reset with `req`=1111, then deassert `reset`: after the first edge, `grant`=0001, address=00, `valid`=1. Outputs read 0 while reset is high.
- `req`=0100 alone: after 1 edge, `grant`=0100, `address1`=1, `address0`=0. Drop `req`: after 1 edge, `grant`=0000, `valid`=0, address stays 10.
- `req`=1111 held, with each owner dropping its bit for one cycle after 3 cycles of ownership: grant order 0001→0010→0100→1000→0001, with no idle cycle between owners.
- Owner index 2 holds, `req`=0110, and owner releases: `grant`=1000 is not produced. The next owner is index 1 via wrap (`ptr`=3, search 3,0,1), so `grant`=0010.
- With `MUX_ARB_TIMEOUT_EN` and `MAX_HOLD`=8, `req`=0011 held high: `grant` alternates 0001 and 0010 every 8 cycles. With `req`=0001 only, the grant persists indefinitely.
- Assert `reset` asynchronously mid-grant (between edges) while `grant`=1000: `grant`, `valid`, and address clear before the next edge. After release, `req`=1001 yields `grant`=0001.

Source files
------------

// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between four requesters, the arbiter and the shared 4:1 mux select.
// master = arbiter side (drives grant/select), slave = requester/mux side.
interface mux_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       valid;

    modport master (input req, output grant, address0, address1, valid);
    modport slave  (output req, input grant, address0, address1, valid);
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter driving the select pair of a shared 4:1 mux; 1-edge req->grant, back-to-back handoff.
// Optional hold timeout compiled in with MUX_ARB_TIMEOUT_EN; all outputs registered, no req->output comb path.
module mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    mux_arbiter_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [3:0] grant_q;
    logic [1:0] addr_q;
    logic       valid_q;
    logic [1:0] ptr;

    logic [3:0] cand_req;
    logic       cand_vld;
    logic [1:0] cand_idx;
    logic       hold_expired;
    logic       handoff;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
`endif

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("mux_arbiter: MAX_HOLD must be in 2..255");
    end

    always_comb begin
        // The current owner never competes against itself for the next slot.
        cand_req = bus.req & ~grant_q;
        cand_vld = 1'b0;
        cand_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[2'(ptr + 2'(k))]) begin
                cand_vld = 1'b1;
                cand_idx = 2'(ptr + 2'(k));
            end
        end
`ifdef MUX_ARB_TIMEOUT_EN
        hold_expired = (hold_cnt == 8'(MAX_HOLD - 1)) && cand_vld;
`else
        hold_expired = 1'b0;
`endif
        if (state == IDLE)
            handoff = cand_vld;
        else
            handoff = !(|(bus.req & grant_q)) || hold_expired;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= 4'b0000;
            addr_q  <= 2'b00;
            valid_q <= 1'b0;
            ptr     <= 2'b00;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE, BUSY: begin
                    if (handoff) begin
                        if (cand_vld) begin
                            state   <= BUSY;
                            grant_q <= 4'b0001 << cand_idx;
                            addr_q  <= cand_idx;
                            valid_q <= 1'b1;
                            ptr     <= cand_idx + 2'd1;
`ifdef MUX_ARB_TIMEOUT_EN
                            hold_cnt <= 8'd0;
`endif
                        end else begin
                            // Address keeps the last owner so the mux select stays quiet.
                            state   <= IDLE;
                            grant_q <= 4'b0000;
                            valid_q <= 1'b0;
                        end
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    else if (state == BUSY && hold_cnt != 8'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.address0 = addr_q[0];
    assign bus.address1 = addr_q[1];
    assign bus.valid    = valid_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: a reference model predicts each edge's outputs, a monitor compares.
module tb_mux_arbiter;
    localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    mux_arbiter_if bus ();

    mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // Reference model state: owner index (-1 = nobody), pointer, hold cycles, last owner.
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_last = 0;
    logic [6:0] exp_q[$];

    function automatic int search(logic [3:0] r, int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic take(input int idx);
        m_owner = idx;
        m_ptr = (idx + 1) % 4;
        m_cnt = 0;
        m_last = idx;
    endtask

    // Model: sampled at each rising edge, pushes the outputs expected right after it.
    initial begin
        logic [3:0] r;
        logic [3:0] others;
        logic [3:0] g;
        int nxt;
        bit leave;
        forever begin
            @(posedge clk);
            r = bus.req;
            if (reset) begin
                m_owner = -1; m_ptr = 0; m_cnt = 0; m_last = 0;
            end else if (m_owner < 0) begin
                nxt = search(r, m_ptr);
                if (nxt >= 0) take(nxt);
            end else begin
                others = r;
                others[m_owner] = 1'b0;
                leave = !r[m_owner] ||
                        (TIMEOUT && m_cnt == MAX_HOLD - 1 && others != 4'b0000);
                if (leave) begin
                    nxt = search(others, m_ptr);
                    if (nxt >= 0) take(nxt);
                    else m_owner = -1;
                end else if (m_cnt < MAX_HOLD - 1) begin
                    m_cnt = m_cnt + 1;
                end
            end
            g = 4'b0000;
            if (m_owner >= 0) g[m_owner] = 1'b1;
            exp_q.push_back({g, m_last[1], m_last[0], m_owner >= 0});
        end
    end

    // Monitor: compares every post-edge output against the oldest prediction.
    initial begin
        logic [6:0] act;
        logic [6:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            act = {bus.grant, bus.address1, bus.address0, bus.valid};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty cycle=%0d actual=%b required=prediction", cycle, act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d actual grant=%b a1a0=%b valid=%b required grant=%b a1a0=%b valid=%b",
                             cycle, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req = r;
        end
    endtask

    task automatic check_now(input string name, input logic [6:0] req_val);
        logic [6:0] act;
        act = {bus.grant, bus.address1, bus.address0, bus.valid};
        checks++;
        if (act !== req_val) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req_val);
        end
    endtask

    initial begin
        logic [3:0] r;
        bus.req = 4'b1111;
        #1;
        check_now("reset_outputs_zero", 7'b0);
        cyc(4'b1111, 3);
        @(negedge clk);
        reset = 1'b0;

        // Round robin with each owner dropping its bit after three cycles of ownership.
        for (int n = 0; n < 6; n++) begin
            cyc(4'b1111, 3);
            @(negedge clk);
            r = 4'b1111;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            bus.req = r;
        end

        // Single requester 2, then release to idle with address held.
        cyc(4'b0000, 2);
        cyc(4'b0100, 2);
        cyc(4'b0000, 2);

        // Owner 2 with 1 waiting: wrap from pointer 3 gives requester 1.
        cyc(4'b0100, 1);
        cyc(4'b0110, 2);
        cyc(4'b0010, 2);
        cyc(4'b0000, 2);

        // Timeout behaviour (or plain holding when the timeout is not built in).
        cyc(4'b0011, 40);
        cyc(4'b0001, 30);
        cyc(4'b0000, 2);

        // Randomized traffic, biased toward the owner keeping its request.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            bus.req = r;
        end

        // Asynchronous reset between edges while requester 3 owns the mux.
        cyc(4'b0000, 2);
        cyc(4'b1000, 3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset_mid_grant", 7'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.req = 4'b1001;
        @(posedge clk);
        #2;
        check_now("first_grant_after_reset", {4'b0001, 2'b00, 1'b1});
        cyc(4'b1001, 3);
        cyc(4'b0000, 3);

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
